// File: rtl/vga_bounce_sprite_if.sv
// vga_bounce_sprite_if
// Pixel-stream bundle between the VGA timing stage and the sprite colour stage.
//   XPOS/YPOS     current pixel column / line from the timing stage
//   DISP_ACTIVE   visible-region flag
//   HSYNC_IN/VSYNC_IN  raw syncs from the timing stage
//   HSYNC/VSYNC   syncs re-registered alongside the colour
//   Ro/Go/Bo      registered 4-bit colour channels
// master: the timing side (drives position/syncs, receives colour)
// slave : the colour stage
interface vga_bounce_sprite_if;
  logic [11:0] XPOS;
  logic [11:0] YPOS;
  logic        DISP_ACTIVE;
  logic        HSYNC_IN;
  logic        VSYNC_IN;
  logic        HSYNC;
  logic        VSYNC;
  logic [3:0]  Ro;
  logic [3:0]  Go;
  logic [3:0]  Bo;

  modport master (
    output XPOS, YPOS, DISP_ACTIVE, HSYNC_IN, VSYNC_IN,
    input  HSYNC, VSYNC, Ro, Go, Bo
  );

  modport slave (
    input  XPOS, YPOS, DISP_ACTIVE, HSYNC_IN, VSYNC_IN,
    output HSYNC, VSYNC, Ro, Go, Bo
  );
endinterface

// File: rtl/vga_bounce_sprite.sv
// vga_bounce_sprite
// Draws one solid rectangle on black, moved once per frame with edge bounces.
// Colour and syncs are registered together so they leave with 1 CLK latency.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   H_VIS/V_VIS visible width/height of the current mode
//   PAUSE      freezes motion (drawing continues)
//   BOUNCES    wrapping 8-bit count of bounce events
//   vid        pixel-stream bundle (slave side)
// Optional build macro VGA_BOUNCE_BORDER_EN: white 1-pixel frame around the
// visible area, drawn on top of the sprite.
module vga_bounce_sprite #(
  parameter int BOX_W   = 40,
  parameter int BOX_H   = 40,
  parameter int STEP    = 2,
  parameter int START_X = 100,
  parameter int START_Y = 60
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [11:0] H_VIS,
  input  logic [11:0] V_VIS,
  input  logic        PAUSE,
  output logic [7:0]  BOUNCES,
  vga_bounce_sprite_if.slave vid
);

  localparam logic [11:0] STEP_V  = 12'(STEP);
  localparam logic [11:0] BOX_W_V = 12'(BOX_W);
  localparam logic [11:0] BOX_H_V = 12'(BOX_H);

  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, COMMIT} state_t;

  typedef struct packed {
    logic [11:0] pos;
    logic        neg;
    logic        bnc;
  } axis_t;

  // One axis of motion. A sprite already past the far edge (after a mode
  // shrink) is clamped back as a bounce even while moving towards the origin.
  function automatic axis_t move_axis(input logic [11:0] pos, input logic neg,
                                      input logic [11:0] vis, input logic [11:0] box);
    axis_t       res;
    logic [12:0] far_edge;
    far_edge = {1'b0, pos} + {1'b0, box};
    res.pos  = pos;
    res.neg  = neg;
    res.bnc  = 1'b0;
    if (!neg) begin
      if (far_edge + {1'b0, STEP_V} > {1'b0, vis}) begin
        res.pos = vis - box;
        res.neg = 1'b1;
        res.bnc = 1'b1;
      end else begin
        res.pos = pos + STEP_V;
      end
    end else begin
      if (far_edge > {1'b0, vis}) begin
        res.pos = vis - box;
        res.bnc = 1'b1;
      end else if (pos < STEP_V) begin
        res.pos = 12'd0;
        res.neg = 1'b0;
        res.bnc = 1'b1;
      end else begin
        res.pos = pos - STEP_V;
      end
    end
    return res;
  endfunction

  // Colour index {R,G,B} walk on each bounce.
  function automatic logic [2:0] next_colour(input logic [2:0] c);
    logic [2:0] n;
    case (c)
      3'b100:  n = 3'b010;
      3'b010:  n = 3'b001;
      3'b001:  n = 3'b110;
      3'b110:  n = 3'b011;
      3'b011:  n = 3'b101;
      3'b101:  n = 3'b111;
      3'b111:  n = 3'b100;
      default: n = 3'b100;
    endcase
    return n;
  endfunction

  state_t      state_r;
  logic [11:0] x_r, y_r, nx_r, ny_r, prev_y_r;
  logic        dx_neg_r, dy_neg_r, xb_r, yb_r;
  logic [2:0]  colour_r;
  logic [7:0]  bounces_r;
  logic        hsync_r, vsync_r;
  logic [3:0]  r_r, g_r, b_r;

  logic        hit_s, tick_s;
  logic [3:0]  r_s, g_s, b_s;
  axis_t       mv_x_s, mv_y_s;

  // 13-bit sums so X+BOX_W cannot wrap near the 12-bit limit.
  assign hit_s = vid.DISP_ACTIVE
               && ({1'b0, vid.XPOS} >= {1'b0, x_r})
               && ({1'b0, vid.XPOS} <  ({1'b0, x_r} + {1'b0, BOX_W_V}))
               && ({1'b0, vid.YPOS} >= {1'b0, y_r})
               && ({1'b0, vid.YPOS} <  ({1'b0, y_r} + {1'b0, BOX_H_V}));

  // Entering vertical blanking; independent of sync polarity.
  assign tick_s = (prev_y_r < V_VIS) && (vid.YPOS >= V_VIS);

`ifdef VGA_BOUNCE_BORDER_EN
  logic border_s;
  assign border_s = vid.DISP_ACTIVE
                  && ((vid.XPOS == 12'd0) || (vid.XPOS == H_VIS - 12'd1)
                   || (vid.YPOS == 12'd0) || (vid.YPOS == V_VIS - 12'd1));
`endif

  // Next-step positions for the axis currently being processed.
  always_comb begin
    mv_x_s = move_axis(nx_r, dx_neg_r, H_VIS, BOX_W_V);
    mv_y_s = move_axis(ny_r, dy_neg_r, V_VIS, BOX_H_V);
  end

  // Pixel colour selection ahead of the output registers.
  always_comb begin
    r_s = 4'h0;
    g_s = 4'h0;
    b_s = 4'h0;
`ifdef VGA_BOUNCE_BORDER_EN
    if (border_s) begin
      r_s = 4'hF;
      g_s = 4'hF;
      b_s = 4'hF;
    end else if (hit_s) begin
      r_s = {4{colour_r[2]}};
      g_s = {4{colour_r[1]}};
      b_s = {4{colour_r[0]}};
    end else begin
      r_s = 4'h0;
      g_s = 4'h0;
      b_s = 4'h0;
    end
`else
    if (hit_s) begin
      r_s = {4{colour_r[2]}};
      g_s = {4{colour_r[1]}};
      b_s = {4{colour_r[0]}};
    end else begin
      r_s = 4'h0;
      g_s = 4'h0;
      b_s = 4'h0;
    end
`endif
  end

  // Motion FSM: working copy NX/NY is only written back in COMMIT, so a
  // reset mid-update leaves no partial position.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      x_r       <= 12'(START_X);
      y_r       <= 12'(START_Y);
      nx_r      <= 12'(START_X);
      ny_r      <= 12'(START_Y);
      dx_neg_r  <= 1'b0;
      dy_neg_r  <= 1'b0;
      xb_r      <= 1'b0;
      yb_r      <= 1'b0;
      colour_r  <= 3'b100;
      bounces_r <= 8'd0;
      prev_y_r  <= 12'd0;
    end else begin
      prev_y_r <= vid.YPOS;
      case (state_r)
        IDLE: begin
          if (tick_s && !PAUSE) begin
            nx_r    <= x_r;
            ny_r    <= y_r;
            xb_r    <= 1'b0;
            yb_r    <= 1'b0;
            state_r <= MOVE_X;
          end else begin
            state_r <= IDLE;
          end
        end
        MOVE_X: begin
          nx_r     <= mv_x_s.pos;
          dx_neg_r <= mv_x_s.neg;
          xb_r     <= mv_x_s.bnc;
          state_r  <= MOVE_Y;
        end
        MOVE_Y: begin
          ny_r     <= mv_y_s.pos;
          dy_neg_r <= mv_y_s.neg;
          yb_r     <= mv_y_s.bnc;
          state_r  <= COMMIT;
        end
        COMMIT: begin
          x_r <= nx_r;
          y_r <= ny_r;
          if (xb_r || yb_r) begin
            colour_r  <= next_colour(colour_r);
            bounces_r <= bounces_r + 8'd1;
          end else begin
            colour_r  <= colour_r;
            bounces_r <= bounces_r;
          end
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Output registers: colour and syncs leave on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hsync_r <= 1'b0;
      vsync_r <= 1'b0;
      r_r     <= 4'h0;
      g_r     <= 4'h0;
      b_r     <= 4'h0;
    end else begin
      hsync_r <= vid.HSYNC_IN;
      vsync_r <= vid.VSYNC_IN;
      r_r     <= r_s;
      g_r     <= g_s;
      b_r     <= b_s;
    end
  end

  assign vid.HSYNC = hsync_r;
  assign vid.VSYNC = vsync_r;
  assign vid.Ro    = r_r;
  assign vid.Go    = g_r;
  assign vid.Bo    = b_r;
  assign BOUNCES   = bounces_r;

endmodule

// File: tb/tb_vga_bounce_sprite.sv
// Bench for vga_bounce_sprite: four instances with different start positions
// share one pixel stream; each is checked against its own behavioural model.
module tb_vga_bounce_sprite;
  localparam int NI   = 4;
  localparam int BW   = 40;
  localparam int BH   = 40;
  localparam int STP  = 2;
  localparam int SX[NI] = '{100, 596, 598, 700};
  localparam int SY[NI] = '{60, 60, 438, 500};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] h_vis [NI];
  logic [11:0] v_vis [NI];
  logic [NI-1:0] pause;
  logic [7:0]  bounces [NI];
  logic [11:0] xpos, ypos;
  logic        disp_active, hsync_in, vsync_in;
  logic [3:0]  ro [NI];
  logic [3:0]  go [NI];
  logic [3:0]  bo [NI];
  logic [NI-1:0] hs_o, vs_o;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_bounce_sprite_if u_if ();
    assign u_if.XPOS        = xpos;
    assign u_if.YPOS        = ypos;
    assign u_if.DISP_ACTIVE = disp_active;
    assign u_if.HSYNC_IN    = hsync_in;
    assign u_if.VSYNC_IN    = vsync_in;
    assign ro[g]   = u_if.Ro;
    assign go[g]   = u_if.Go;
    assign bo[g]   = u_if.Bo;
    assign hs_o[g] = u_if.HSYNC;
    assign vs_o[g] = u_if.VSYNC;
    vga_bounce_sprite #(.BOX_W(BW), .BOX_H(BH), .STEP(STP),
                        .START_X(SX[g]), .START_Y(SY[g])) u_dut (
      .CLK(clk), .RST(rst), .H_VIS(h_vis[g]), .V_VIS(v_vis[g]),
      .PAUSE(pause[g]), .BOUNCES(bounces[g]), .vid(u_if.slave)
    );
  end

  // Behavioural model: position, direction, colour-walk index, bounce count.
  localparam logic [2:0] SEQ [7] = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111};
  int mx [NI];
  int my [NI];
  bit mdxn [NI];
  bit mdyn [NI];
  int mci [NI];
  int mb [NI];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mx[k] = SX[k]; my[k] = SY[k]; mdxn[k] = 1'b0; mdyn[k] = 1'b0; mci[k] = 0; mb[k] = 0;
    end
  endtask

  // Reflect off the walls; a sprite beyond the far wall snaps back inside.
  function automatic void axis(input int p, input bit neg, input int vis, input int box,
                               output int np, output bit nneg, output bit b);
    np = p; nneg = neg; b = 1'b0;
    if (p + box > vis || (!neg && p + STP + box > vis)) begin
      np = vis - box; nneg = 1'b1; b = 1'b1;
    end else if (!neg) begin
      np = p + STP;
    end else if (p < STP) begin
      np = 0; nneg = 1'b0; b = 1'b1;
    end else begin
      np = p - STP;
    end
  endfunction

  task automatic model_update(input int k);
    int nx, ny;
    bit ndx, ndy, bx, by;
    axis(mx[k], mdxn[k], int'(h_vis[k]), BW, nx, ndx, bx);
    axis(my[k], mdyn[k], int'(v_vis[k]), BH, ny, ndy, by);
    mx[k] = nx; my[k] = ny; mdxn[k] = ndx; mdyn[k] = ndy;
    if (bx || by) begin
      mci[k] = (mci[k] + 1) % 7;
      mb[k]  = (mb[k] + 1) % 256;
    end
  endtask

  function automatic logic [11:0] exp_pix(input int k, input int x, input int y, input bit act);
    logic [2:0] c;
`ifdef VGA_BOUNCE_BORDER_EN
    if (act && (x == 0 || x == int'(h_vis[k]) - 1 || y == 0 || y == int'(v_vis[k]) - 1))
      return 12'hFFF;
`endif
    if (act && x >= mx[k] && x < mx[k] + BW && y >= my[k] && y < my[k] + BH) begin
      c = SEQ[mci[k]];
      return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
    end
    return 12'h000;
  endfunction

  // Present one pixel, then compare every instance one CLK later.
  task automatic probe(input int x, input int y, input bit act, input bit hs, input bit vs);
    logic [11:0] e;
    xpos = 12'(x); ypos = 12'(y); disp_active = act; hsync_in = hs; vsync_in = vs;
    step();
    for (int k = 0; k < NI; k++) begin
      e = exp_pix(k, x, y, act);
      chk("pix_rgb", k, {ro[k], go[k], bo[k]}, int'(e));
      chk("hsync", k, hs_o[k], int'(hs));
      chk("vsync", k, vs_o[k], int'(vs));
      chk("bounces", k, bounces[k], mb[k]);
    end
  endtask

  task automatic hand(input string name, input int k, input int x, input int y, input int rgb);
    probe(x, y, 1'b1, 1'b0, 1'b0);
    chk(name, k, {ro[k], go[k], bo[k]}, rgb);
  endtask

  // Frame tick: YPOS crosses into blanking, then stays there while updates run.
  task automatic tick();
    disp_active = 1'b0; xpos = 12'd0; ypos = 12'd0;
    step();
    ypos = 12'd1000;
    step();
    for (int k = 0; k < NI; k++) if (!pause[k]) model_update(k);
    repeat (5) step();
  endtask

  task automatic rand_probes(input int n);
    int k, x, y;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, NI - 1);
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom_range(0, 799);
        y = $urandom_range(0, 479);
        if ($urandom_range(0, 3) == 0) x = ($urandom_range(0, 1) == 0) ? 0 : int'(h_vis[k]) - 1;
      end else begin
        x = mx[k] - 2 + $urandom_range(0, BW + 3);
        y = my[k] - 2 + $urandom_range(0, BH + 3);
      end
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      if (y > 479) y = 479;
      probe(x, y, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  typedef struct {
    int          x;
    int          y;
    bit          act;
    logic [11:0] rgb;
  } vec_t;

  vec_t tv [9];
  logic [11:0] edge_rgb;

  initial begin
`ifdef VGA_BOUNCE_BORDER_EN
    edge_rgb = 12'hFFF;
`else
    edge_rgb = 12'h000;
`endif
    tv[0] = '{100, 60, 1'b1, 12'hF00};
    tv[1] = '{139, 99, 1'b1, 12'hF00};
    tv[2] = '{140, 60, 1'b1, 12'h000};
    tv[3] = '{99, 60, 1'b1, 12'h000};
    tv[4] = '{100, 100, 1'b1, 12'h000};
    tv[5] = '{120, 80, 1'b0, 12'h000};
    tv[6] = '{120, 80, 1'b1, 12'hF00};
    tv[7] = '{0, 0, 1'b1, edge_rgb};
    tv[8] = '{639, 479, 1'b1, edge_rgb};

    for (int k = 0; k < NI; k++) begin
      h_vis[k] = (k == 3) ? 12'd800 : 12'd640;
      v_vis[k] = (k == 3) ? 12'd600 : 12'd480;
    end
    pause = '0;
    model_reset();

    // Reset holds outputs low even with live inputs.
    rst = 1'b1; xpos = 12'd100; ypos = 12'd60; disp_active = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1;
    step();
    for (int k = 0; k < NI; k++) begin
      chk("rst_rgb", k, {ro[k], go[k], bo[k]}, 0);
      chk("rst_hsync", k, hs_o[k], 0);
      chk("rst_vsync", k, vs_o[k], 0);
      chk("rst_bounces", k, bounces[k], 0);
    end
    ypos = 12'd0; hsync_in = 1'b0; vsync_in = 1'b0; disp_active = 1'b0;
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      probe(tv[i].x, tv[i].y, tv[i].act, 1'b0, 1'b0);
      chk("table", 0, {ro[0], go[0], bo[0]}, int'(tv[i].rgb));
    end

    // Ten motion frames; walls and corner on the offset instances.
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) begin
        h_vis[3] = 12'd640;
        v_vis[3] = 12'd480;
      end
      if (i == 2) begin
        hand("corner_pix", 2, 600, 440, 12'h0F0);
        hand("mode_clamp_pix", 3, 600, 440, 12'h0F0);
        chk("corner_bounces", 2, bounces[2], 1);
        chk("mode_bounces", 3, bounces[3], 1);
      end
      if (i == 3) begin
        hand("wall_pix", 1, 600, 66, 12'h0F0);
        hand("wall_left_out", 1, 599, 66, 12'h000);
        chk("wall_bounces", 1, bounces[1], 1);
        hand("corner_back", 2, 598, 438, 12'h0F0);
        hand("mode_back", 3, 598, 438, 12'h0F0);
      end
      if (i == 4) begin
        hand("wall_back", 1, 598, 68, 12'h0F0);
        hand("wall_back_out", 1, 597, 68, 12'h000);
      end
      rand_probes(10);
    end
    hand("moved_tl", 0, 120, 80, 12'hF00);
    hand("moved_left_out", 0, 119, 80, 12'h000);
    hand("moved_br", 0, 159, 119, 12'hF00);
    hand("moved_right_out", 0, 160, 119, 12'h000);
    hand("moved_top_out", 0, 120, 79, 12'h000);

    // Paused ticks leave every sprite in place.
    pause = '1;
    repeat (5) tick();
    hand("pause_tl", 0, 120, 80, 12'hF00);
    hand("pause_left_out", 0, 119, 80, 12'h000);
    rand_probes(10);

    // Random pauses and occasional mode flips on instance 0.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NI; k++) pause[k] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        h_vis[0] = (h_vis[0] == 12'd640) ? 12'd800 : 12'd640;
        v_vis[0] = (v_vis[0] == 12'd480) ? 12'd600 : 12'd480;
      end
      tick();
      rand_probes(12);
    end

    // Reset while the FSM sits in MOVE_Y: update abandoned, start position back.
    h_vis[0] = 12'd640; v_vis[0] = 12'd480; pause = '0;
    disp_active = 1'b0; ypos = 12'd0;
    step();
    ypos = 12'd1000;
    step();
    step();
    rst = 1'b1; ypos = 12'd0; xpos = 12'd100; disp_active = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1;
    step();
    for (int k = 0; k < NI; k++) begin
      chk("midrst_rgb", k, {ro[k], go[k], bo[k]}, 0);
      chk("midrst_hsync", k, hs_o[k], 0);
      chk("midrst_bounces", k, bounces[k], 0);
    end
    model_reset();
    rst = 1'b0; disp_active = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    step();
    hand("post_rst_tl", 0, 100, 60, 12'hF00);
    hand("post_rst_out", 0, 140, 60, 12'h000);
    tick();
    hand("post_rst_move", 0, 102, 62, 12'hF00);
    hand("post_rst_move_out", 0, 101, 62, 12'h000);
    rand_probes(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
